// File: rtl/mul4_eval_pkg.sv
// Shared constants and types for the 2x2-bit multiplier candidate scorer.
// Lane i of every 16-bit word carries a = i[3:2], b = i[1:0].
package mul4_eval_pkg;

  localparam int SCORE_W_DFLT = 7;

  // Exhaustive operand lanes
  localparam logic [15:0] LANE_A1 = 16'hFF00;
  localparam logic [15:0] LANE_A0 = 16'hF0F0;
  localparam logic [15:0] LANE_B1 = 16'hCCCC;
  localparam logic [15:0] LANE_B0 = 16'hAAAA;

  // Correct product bits per lane
  localparam logic [15:0] GOLD_Y3 = 16'h8000;
  localparam logic [15:0] GOLD_Y2 = 16'h4C00;
  localparam logic [15:0] GOLD_Y1 = 16'h6AC0;
  localparam logic [15:0] GOLD_Y0 = 16'hA0A0;
  localparam logic [63:0] GOLD_Y  = {GOLD_Y3, GOLD_Y2, GOLD_Y1, GOLD_Y0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE_W,
    ST_SAMPLE,
    ST_SCORE,
    ST_NEXT
  } state_e;

endpackage

// File: rtl/mul4_lane_scorer.sv
// Combinational compare of one candidate's 64 output bits against the golden
// product, plus a popcount of an (externally registered) match vector.
module mul4_lane_scorer
  import mul4_eval_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DFLT
) (
  input  logic [63:0]        y_i,
  output logic [63:0]        match_o,
  input  logic [63:0]        match_i,
  output logic [SCORE_W-1:0] score_o
);

  assign match_o = ~(y_i ^ GOLD_Y);

  // Count matching bits; 64 fits in 7 bits so no saturation is needed
  always_comb begin
    score_o = '0;
    for (int i = 0; i < 64; i++) begin
      score_o = score_o + SCORE_W'(match_i[i]);
    end
  end

endmodule

// File: rtl/mul4_fitness_sched.sv
// Sequencer/scorer: walks cand_sel across NUM_CAND candidates, waits SETTLE
// cycles for the external mux, samples the match vector, scores it and keeps
// the best (strictly greater wins, so ties keep the lower index).
module mul4_fitness_sched
  import mul4_eval_pkg::*;
#(
  parameter  int NUM_CAND = 4,
  parameter  int SETTLE   = 1,
  parameter  int SCORE_W  = SCORE_W_DFLT,
  localparam int SEL_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 a1,
  output logic [15:0]                 a0,
  output logic [15:0]                 b1,
  output logic [15:0]                 b0,
  output logic [SEL_W-1:0]            cand_sel,
  input  logic [15:0]                 cand_y3,
  input  logic [15:0]                 cand_y2,
  input  logic [15:0]                 cand_y1,
  input  logic [15:0]                 cand_y0,
  output logic [NUM_CAND*SCORE_W-1:0] score_flat,
  output logic [SEL_W-1:0]            best_idx,
  output logic [SCORE_W-1:0]          best_score,
  output logic                        scores_valid
);

  localparam int               CNT_W    = 3;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CAND - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(SETTLE - 1);

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [SEL_W-1:0]            sel_q, sel_d;
  logic [63:0]                 match_q, match_d;
  logic [NUM_CAND*SCORE_W-1:0] flat_q, flat_d;
  logic [SEL_W-1:0]            best_idx_q, best_idx_d;
  logic [SCORE_W-1:0]          best_score_q, best_score_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        valid_q, valid_d;

  logic [63:0]                 match_c;
  logic [SCORE_W-1:0]          score_c;

  mul4_lane_scorer #(
    .SCORE_W (SCORE_W)
  ) u_scorer (
    .y_i     ({cand_y3, cand_y2, cand_y1, cand_y0}),
    .match_o (match_c),
    .match_i (match_q),
    .score_o (score_c)
  );

  // Next-state and output-register logic; abort overrides everything once busy
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    match_d      = match_q;
    flat_d       = flat_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    valid_d      = valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_SETTLE_W;
          cnt_d        = '0;
          sel_d        = '0;
          flat_d       = '0;
          best_idx_d   = '0;
          best_score_d = '0;
          busy_d       = 1'b1;
          valid_d      = 1'b0;
        end
      end
      ST_SETTLE_W: begin
        if (cnt_q == CNT_END) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        match_d = match_c;
        state_d = ST_SCORE;
      end
      ST_SCORE: begin
        for (int k = 0; k < NUM_CAND; k++) begin
          if (sel_q == SEL_W'(k)) begin
            flat_d[k*SCORE_W +: SCORE_W] = score_c;
          end
        end
        if ((sel_q == '0) || (score_c > best_score_q)) begin
          best_idx_d   = sel_q;
          best_score_d = score_c;
        end
        // Completion flags are registered here so they show during NEXT
        if (sel_q == LAST_SEL) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (sel_q == LAST_SEL) begin
          state_d = ST_IDLE;
        end else begin
          sel_d   = sel_q + SEL_W'(1);
          cnt_d   = '0;
          state_d = ST_SETTLE_W;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      valid_d = 1'b0;
    end
  end

  // State and result registers; all clear on asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      match_q      <= '0;
      flat_q       <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      match_q      <= match_d;
      flat_q       <= flat_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
    end
  end

  assign a1           = LANE_A1;
  assign a0           = LANE_A0;
  assign b1           = LANE_B1;
  assign b0           = LANE_B0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cand_sel     = sel_q;
  assign score_flat   = flat_q;
  assign best_idx     = best_idx_q;
  assign best_score   = best_score_q;
  assign scores_valid = valid_q;

endmodule

// File: doc/mul4_fitness_sched.md
Name: mul4_fitness_sched

Overview:
Sequencer and scorer for bit-sliced 2x2-bit multiplier candidates (4-bit product, 16 lanes per 16-bit word).
- Drives the exhaustive test-vector set on the a1/a0/b1/b0 lanes.
- Time-shares one candidate result bus across NUM_CAND candidates through cand_sel.
- Counts correct output bits per candidate and reports per-candidate scores plus the best candidate.
- Sits between the GE evaluation harness and a bank of combinational candidate individuals.

Parameters:
- NUM_CAND, 4, number of candidates scored per run (1..16).
- SETTLE, 1, cycles from cand_sel change to sampling cand_y* (1..7); covers external mux/pipeline delay.
- SCORE_W, 7, score width; max score 64 (4 outputs x 16 lanes).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- abort  in  1  synchronous abort of a run in progress.
- busy  out  1  high from accepted start until done/abort.
- done  out  1  one-cycle pulse when all candidates are scored.
- a1, a0, b1, b0  out  16 each  test-vector lanes to the candidate.
- cand_sel  out  $clog2(NUM_CAND) (min 1)  index of the candidate currently driven onto cand_y*.
- cand_y3, cand_y2, cand_y1, cand_y0  in  16 each  selected candidate's outputs.
- score_flat  out  NUM_CAND*SCORE_W  score of candidate k in bits [k*SCORE_W +: SCORE_W].
- best_idx  out  $clog2(NUM_CAND) (min 1)  highest-scoring candidate.
- best_score  out  SCORE_W  its score.
- scores_valid  out  1  high after a completed run, until the next accepted start or abort.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: all outputs 0, except a1/a0/b1/b0, which are constant. Reset mid-run returns to IDLE with no done pulse.
- Lane encoding: lane i has a = i[3:2], b = i[1:0]. Constant vectors: a1=16'hFF00, a0=16'hF0F0, b1=16'hCCCC, b0=16'hAAAA.
- Golden product: y3=16'h8000, y2=16'h4C00, y1=16'h6AC0, y0=16'hA0A0.
- States: IDLE, SETTLE_W, SAMPLE, SCORE, NEXT.
- IDLE:
  - start -> SETTLE_W, with cand_sel=0, busy=1, scores_valid=0, score_flat cleared, best_idx/best_score cleared.
  - start while busy is ignored.
- SETTLE_W: counts SETTLE cycles, then -> SAMPLE.
- SAMPLE:
  - Registers cand_y* XNOR golden, giving a 64-bit match vector.
  - -> SCORE.
- SCORE:
  - Registers popcount(match) into slot cand_sel.
  - Updates best if the new score is strictly greater than best_score. Ties keep the lower index; candidate 0 always seeds best.
  - -> NEXT.
- NEXT:
  - If cand_sel == NUM_CAND-1: done=1 for one cycle, scores_valid=1, busy=0, -> IDLE.
  - Otherwise cand_sel+1 -> SETTLE_W.
- Latency: (SETTLE+3) cycles per candidate. done asserts NUM_CAND*(SETTLE+3) cycles after the start cycle.
- cand_sel changes only on entry to SETTLE_W and is stable through SAMPLE. After done it holds its last value.
- abort, in any non-IDLE state: -> IDLE next cycle, busy=0, no done, scores_valid stays 0. Partial scores remain visible but are invalid. abort in IDLE has no effect.
- start and abort in the same cycle while IDLE: start wins. While busy: abort wins.
- Arithmetic: popcount of 64 bits fits SCORE_W=7 with no saturation needed. The best comparison is unsigned.

Decomposition:
- Package mul4_eval_pkg holds:
  - the lane-vector and golden constants;
  - the state enum typedef;
  - the SCORE_W localparam default.
- One sub-module: mul4_lane_scorer (combinational 64-bit XNOR-compare plus popcount, output SCORE_W). The FSM registers its input and output.

Test Plan:
1. Perfect candidate on all slots (cand_y = golden), NUM_CAND=4, SETTLE=1 -> every score 64, best_idx=0, done at cycle 16 after start, scores_valid=1.
2. Slot k outputs all zeros, all-ones, golden, inverted golden for k=0..3 -> scores 50, 14, 64, 0; best_idx=2, best_score=64.
3. Tie: slots 1 and 3 both golden, slots 0 and 2 all-zero -> best_idx=1, best_score=64.
4. abort asserted during candidate 2's SETTLE_W -> busy=0 next cycle, no done pulse, scores_valid=0. A new start then completes normally.
5. rst_n low mid-SAMPLE -> all outputs 0 immediately (async); after release, start runs the full sequence.
6. start pulsed again while busy and SETTLE=3 -> ignored; done exactly once at cycle 24; cand_sel sequence 0,1,2,3, each held 6 cycles.
